// File: rtl/gpio_bcd_display_if.sv
// Bundle between the cpu gpio_out and the BCD seven-segment display block.
// The master side drives value_in. The slave side (the display) returns the result and status.
interface gpio_bcd_display_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic [WIDTH-1:0]    value_in;
  logic [4*DIGITS-1:0] bcd;
  logic [6:0]          hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic                valid;
  logic                busy;
  logic                overflow;

  modport master (
    output value_in,
    input  bcd, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7,
    input  valid, busy, overflow
  );

  modport slave (
    input  value_in,
    output bcd, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7,
    output valid, busy, overflow
  );
endinterface

// File: rtl/gpio_bcd_display.sv
// Binary-to-BCD converter (serial double-dabble, one bit per clock) driving eight active-low
// seven-segment digits. It re-converts whenever value_in differs from the last converted value.
module gpio_bcd_display #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 10,
  parameter int BLANK_LZ = 1
) (
  input logic              clk,
  input logic              rst,
  gpio_bcd_display_if.slave io
);
  localparam int CW    = $clog2(WIDTH);
  localparam int SHOWN = 8;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

  state_t                       state_q, state_d;
  logic                         force_q, force_d;
  logic [WIDTH-1:0]             last_q, last_d;
  logic [WIDTH-1:0]             sh_q, sh_d;
  logic [4*DIGITS-1:0]          acc_q, acc_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [4*DIGITS-1:0]          bcd_q, bcd_d;
  logic [SHOWN-1:0][6:0]        hex_q, hex_d;
  logic                         valid_q, valid_d;
  logic                         busy_q, busy_d;
  logic                         ovf_q, ovf_d;
  logic [4*DIGITS-1:0]          acc_adj;
  logic [SHOWN-1:0][6:0]        hex_enc;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = BLANK;
    endcase
  endfunction

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // A leading zero is judged against the full result, including the undisplayed digits,
  // so an overflowing value never blanks its zero digits.
  always_comb begin
    logic        higher_zero;
    logic [3:0]  dig;
    int unsigned idx;
    hex_enc     = {SHOWN{BLANK}};
    higher_zero = 1'b1;
    dig         = '0;
    idx         = 0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      idx = DIGITS - 1 - i;
      dig = acc_q[4*idx +: 4];
      if (idx < SHOWN) begin
        if (BLANK_LZ != 0 && idx != 0 && dig == 4'd0 && higher_zero)
          hex_enc[idx[2:0]] = BLANK;
        else
          hex_enc[idx[2:0]] = seg7(dig);
      end
      higher_zero = higher_zero & (dig == 4'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    force_d = force_q;
    last_d  = last_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    hex_d   = hex_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (force_q || io.value_in != last_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        sh_d    = io.value_in;
        last_d  = io.value_in;
        acc_d   = '0;
        cnt_d   = '0;
        force_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = {acc_adj[4*DIGITS-2:0], sh_q[WIDTH-1]};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = acc_q;
        ovf_d   = |acc_q[4*DIGITS-1:4*SHOWN];
        hex_d   = hex_enc;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy follows the next state so that the output itself comes straight from a flop
    busy_d = (state_d == CAPTURE) || (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      force_q <= 1'b1;
      last_q  <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      hex_q   <= {SHOWN{BLANK}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      force_q <= force_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.bcd      = bcd_q;
  assign io.hex0     = hex_q[0];
  assign io.hex1     = hex_q[1];
  assign io.hex2     = hex_q[2];
  assign io.hex3     = hex_q[3];
  assign io.hex4     = hex_q[4];
  assign io.hex5     = hex_q[5];
  assign io.hex6     = hex_q[6];
  assign io.hex7     = hex_q[7];
  assign io.valid    = valid_q;
  assign io.busy     = busy_q;
  assign io.overflow = ovf_q;
endmodule
